// File: rtl/hash_row_merger_fifo_if.sv
// Handshake bundle for the row merger: sparse input beats in, merged issue rows out.
interface hash_row_merger_fifo_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MML_W  = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_W-1:0]         in_head_addr;
    logic [LANES-1:0]          in_row_valid;
    logic [LANES-1:0]          in_hist_valid;
    logic [LANES*ADDR_W-1:0]   in_hist_addr;
    logic [LANES*MML_W-1:0]    in_mml;
    logic [LANES-1:0]          in_can_ext;
    logic [LANES*8-1:0]        in_data;
    logic                      in_delim;

    logic                      out_valid;
    logic                      out_ready;
    logic [ADDR_W-1:0]         out_head_addr;
    logic [LANES-1:0]          out_row_valid;
    logic [LANES-1:0]          out_hist_valid;
    logic [LANES*ADDR_W-1:0]   out_hist_addr;
    logic [LANES*MML_W-1:0]    out_mml;
    logic [LANES-1:0]          out_can_ext;
    logic [LANES*8-1:0]        out_data;
    logic                      out_delim;
    logic [1:0]                out_cause;

    modport master (
        output in_valid, in_head_addr, in_row_valid, in_hist_valid, in_hist_addr,
               in_mml, in_can_ext, in_data, in_delim, out_ready,
        input  in_ready, out_valid, out_head_addr, out_row_valid, out_hist_valid,
               out_hist_addr, out_mml, out_can_ext, out_data, out_delim, out_cause
    );

    modport slave (
        input  in_valid, in_head_addr, in_row_valid, in_hist_valid, in_hist_addr,
               in_mml, in_can_ext, in_data, in_delim, out_ready,
        output in_ready, out_valid, out_head_addr, out_row_valid, out_hist_valid,
               out_hist_addr, out_mml, out_can_ext, out_data, out_delim, out_cause
    );
endinterface

// File: rtl/hash_row_merger_fifo.sv
// Merges sparse per-lane hash beats into complete issue rows and queues them
// in a DEPTH-entry FIFO, tagging each row with the reason it was flushed.
module hash_row_merger_fifo #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MML_W  = 5,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TMO_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LANES):0]   cfg_max_beats,
    input  logic [TMO_W-1:0]         cfg_timeout,
    hash_row_merger_fifo_if.slave    bus,
    output logic [31:0]              flush_cnt
);
    localparam int unsigned CW   = $clog2(LANES) + 1;
    localparam int unsigned CW1  = CW + 1;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]       head_addr;
        logic [LANES-1:0]        row_valid;
        logic [LANES-1:0]        hist_valid;
        logic [LANES*ADDR_W-1:0] hist_addr;
        logic [LANES*MML_W-1:0]  mml;
        logic [LANES-1:0]        can_ext;
        logic [LANES*8-1:0]      data;
        logic                    delim;
    } row_t;

    typedef struct packed {
        row_t       row;
        logic [1:0] cause;
    } entry_t;

    typedef enum logic {S_RECV, S_DRAIN} state_t;

    state_t            state, state_nxt;
    row_t              acc, merged;
    logic [CW-1:0]     acc_beats;
    logic [TMO_W-1:0]  idle_cnt;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;
    logic              fifo_full, pop;

    logic              acc_nonempty, collision, timeout_hit;
    logic              hit_count, hit_full, flush_cond;
    logic              accept, push, flush_accept, drain_push;
    logic [CW-1:0]     max_eff;
    logic [1:0]        accept_cause;
    entry_t            push_entry;

    assign fifo_full    = (count == CNTW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign pop          = bus.out_valid & bus.out_ready;

    assign acc_nonempty = |acc.row_valid;
    assign collision    = bus.in_valid & |(bus.in_row_valid & acc.row_valid);
    assign max_eff      = (cfg_max_beats == '0) ? CW'(1) : cfg_max_beats;
    assign hit_count    = (CW1'(acc_beats) + CW1'(1)) >= CW1'(max_eff);
    assign hit_full     = &merged.row_valid;
    assign flush_cond   = hit_count | hit_full | bus.in_delim;
    assign accept_cause = bus.in_delim ? 2'd2 : (hit_full ? 2'd1 : 2'd0);
    assign timeout_hit  = acc_nonempty & ~bus.in_valid & (cfg_timeout != '0)
                        & (idle_cnt == cfg_timeout - TMO_W'(1));

    // Lanes carried by the beat overwrite the accumulator; hist_valid stays masked by row_valid.
    always_comb begin
        merged           = acc;
        merged.head_addr = bus.in_head_addr;
        merged.data      = bus.in_data;
        merged.delim     = bus.in_delim;
        merged.row_valid = acc.row_valid | bus.in_row_valid;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.in_row_valid[i]) begin
                merged.hist_valid[i]                  = bus.in_hist_valid[i];
                merged.hist_addr[i*ADDR_W +: ADDR_W]  = bus.in_hist_addr[i*ADDR_W +: ADDR_W];
                merged.mml[i*MML_W +: MML_W]          = bus.in_mml[i*MML_W +: MML_W];
                merged.can_ext[i]                     = bus.in_can_ext[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RECV;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        flush_accept = 1'b0;
        drain_push   = 1'b0;
        push         = 1'b0;
        push_entry   = '{row: merged, cause: accept_cause};
        case (state)
            S_RECV: begin
                bus.in_ready = ~rst & ~fifo_full & ~collision;
                accept       = bus.in_valid & bus.in_ready;
                flush_accept = accept & flush_cond;
                push         = flush_accept;
                if (collision | timeout_hit) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (~fifo_full) begin
                    drain_push = 1'b1;
                    push       = 1'b1;
                    push_entry = '{row: acc, cause: 2'd3};
                    state_nxt  = S_RECV;
                end
            end
            default: state_nxt = S_RECV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            acc_beats <= '0;
            idle_cnt  <= '0;
        end else begin
            if (flush_accept | drain_push) begin
                acc       <= '0;
                acc_beats <= '0;
            end else if (accept) begin
                acc       <= merged;
                acc_beats <= acc_beats + CW'(1);
            end
            if (accept | push)      idle_cnt <= '0;
            else if (acc_nonempty)  idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flush_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: out_valid is derived from count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign bus.out_head_addr  = mem[rd_ptr].row.head_addr;
    assign bus.out_row_valid  = mem[rd_ptr].row.row_valid;
    assign bus.out_hist_valid = mem[rd_ptr].row.hist_valid & mem[rd_ptr].row.row_valid;
    assign bus.out_hist_addr  = mem[rd_ptr].row.hist_addr;
    assign bus.out_mml        = mem[rd_ptr].row.mml;
    assign bus.out_can_ext    = mem[rd_ptr].row.can_ext;
    assign bus.out_data       = mem[rd_ptr].row.data;
    assign bus.out_delim      = mem[rd_ptr].row.delim;
    assign bus.out_cause      = mem[rd_ptr].cause;
endmodule

// File: tb/tb_hash_row_merger_fifo.sv
// Directed bench for hash_row_merger_fifo: count/full/delim/collision/timeout
// flushes, FIFO back-pressure and ordering, and reset mid-row.
module tb_hash_row_merger_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfg_max_beats = 4'd2;
    logic [7:0]  cfg_timeout = 8'd0;
    logic [31:0] flush_cnt;
    int          checks = 0;
    int          failures = 0;

    hash_row_merger_fifo_if #(.LANES(8), .ADDR_W(32), .MML_W(5)) bus ();

    hash_row_merger_fifo #(
        .LANES(8), .ADDR_W(32), .MML_W(5), .DEPTH(4), .TMO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_max_beats(cfg_max_beats),
        .cfg_timeout(cfg_timeout),
        .bus(bus),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] rv, input logic [7:0] hv, input logic [31:0] head,
                        input logic [4:0] mml, input logic [63:0] data, input logic delim);
        bus.in_valid      = 1'b1;
        bus.in_row_valid  = rv;
        bus.in_hist_valid = hv;
        bus.in_head_addr  = head;
        for (int i = 0; i < 8; i++) begin
            bus.in_hist_addr[i*32 +: 32] = head + 32'(i);
            bus.in_mml[i*5 +: 5]         = mml;
            bus.in_can_ext[i]            = mml[0];
        end
        bus.in_data  = data;
        bus.in_delim = delim;
    endtask

    task automatic idle_in();
        bus.in_valid     = 1'b0;
        bus.in_row_valid = '0;
        bus.in_delim     = 1'b0;
    endtask

    initial begin
        logic [4:0] mml0, mml7;
        idle_in();
        bus.in_hist_valid = '0;
        bus.in_head_addr  = '0;
        bus.in_hist_addr  = '0;
        bus.in_mml        = '0;
        bus.in_can_ext    = '0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b1;

        // Reset state
        #2;
        chk("rst_in_ready", 256'(bus.in_ready), 256'd0);
        chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
        chk("rst_flush_cnt", 256'(flush_cnt), 256'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Two halves make a full row; full row beats count in cause priority
        cfg_max_beats = 4'd2;
        beat(8'h0F, 8'hFF, 32'h100, 5'd3, 64'h1111_1111_1111_1111, 1'b0);
        #1 chk("t1_ready_b1", 256'(bus.in_ready), 256'd1);
        tick();
        beat(8'hF0, 8'h30, 32'h200, 5'd8, 64'h2222_2222_2222_2222, 1'b0);
        #1 chk("t1_ready_b2", 256'(bus.in_ready), 256'd1);
        chk("t1_no_early_out", 256'(bus.out_valid), 256'd0);
        tick();
        idle_in();
        #1;
        mml0 = bus.out_mml[4:0];
        mml7 = bus.out_mml[39:35];
        chk("t1_out_valid", 256'(bus.out_valid), 256'd1);
        chk("t1_row_valid", 256'(bus.out_row_valid), 256'hFF);
        chk("t1_cause", 256'(bus.out_cause), 256'd1);
        chk("t1_flush_cnt", 256'(flush_cnt), 256'd1);
        chk("t1_hist_valid", 256'(bus.out_hist_valid), 256'h3F);
        chk("t1_head_addr", 256'(bus.out_head_addr), 256'h200);
        chk("t1_hist_addr_l0", 256'(bus.out_hist_addr[31:0]), 256'h100);
        chk("t1_hist_addr_l7", 256'(bus.out_hist_addr[255:224]), 256'h207);
        chk("t1_mml_l0", 256'(mml0), 256'd3);
        chk("t1_mml_l7", 256'(mml7), 256'd8);
        chk("t1_can_ext", 256'(bus.out_can_ext), 256'h0F);
        chk("t1_data", 256'(bus.out_data), 256'h2222_2222_2222_2222);
        chk("t1_delim", 256'(bus.out_delim), 256'd0);
        tick();
        chk("t1_popped", 256'(bus.out_valid), 256'd0);

        // Delimiter forces a flush before the beat count is reached
        cfg_max_beats = 4'd4;
        beat(8'h01, 8'h01, 32'h300, 5'd1, 64'h3, 1'b0);
        tick();
        beat(8'h02, 8'h02, 32'h304, 5'd1, 64'h4, 1'b1);
        tick();
        idle_in();
        #1;
        chk("t2_row_valid", 256'(bus.out_row_valid), 256'h03);
        chk("t2_delim", 256'(bus.out_delim), 256'd1);
        chk("t2_cause", 256'(bus.out_cause), 256'd2);
        chk("t2_head_addr", 256'(bus.out_head_addr), 256'h304);
        chk("t2_flush_cnt", 256'(flush_cnt), 256'd2);
        tick();

        // Lane collision drains the partial row, then the colliding beat is taken
        beat(8'h03, 8'h03, 32'h400, 5'd2, 64'h5, 1'b0);
        tick();
        beat(8'h06, 8'h06, 32'h500, 5'd2, 64'h6, 1'b0);
        #1 chk("t3_collide_ready", 256'(bus.in_ready), 256'd0);
        tick();
        chk("t3_drain_ready", 256'(bus.in_ready), 256'd0);
        chk("t3_drain_no_out", 256'(bus.out_valid), 256'd0);
        tick();
        chk("t3_out_valid", 256'(bus.out_valid), 256'd1);
        chk("t3_row_valid", 256'(bus.out_row_valid), 256'h03);
        chk("t3_cause", 256'(bus.out_cause), 256'd3);
        chk("t3_head_addr", 256'(bus.out_head_addr), 256'h400);
        chk("t3_flush_cnt", 256'(flush_cnt), 256'd3);
        chk("t3_retry_ready", 256'(bus.in_ready), 256'd1);
        tick();
        idle_in();
        #1 chk("t3_popped", 256'(bus.out_valid), 256'd0);
        beat(8'h00, 8'h00, 32'h600, 5'd0, 64'h7, 1'b1);
        tick();
        idle_in();
        #1;
        chk("t3_second_row", 256'(bus.out_row_valid), 256'h06);
        chk("t3_second_cause", 256'(bus.out_cause), 256'd2);
        chk("t3_second_head", 256'(bus.out_head_addr), 256'h600);
        chk("t3_flush_cnt2", 256'(flush_cnt), 256'd4);
        tick();

        // Idle timeout of 5 cycles flushes a partial row
        cfg_timeout = 8'd5;
        beat(8'h01, 8'h01, 32'h700, 5'd4, 64'h8, 1'b0);
        tick();
        idle_in();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t4_wait_no_out", 256'(bus.out_valid), 256'd0);
        end
        tick();
        chk("t4_out_valid", 256'(bus.out_valid), 256'd1);
        chk("t4_row_valid", 256'(bus.out_row_valid), 256'h01);
        chk("t4_cause", 256'(bus.out_cause), 256'd3);
        chk("t4_flush_cnt", 256'(flush_cnt), 256'd5);
        tick();

        // Timeout disabled: partial row waits indefinitely
        cfg_timeout = 8'd0;
        beat(8'h01, 8'h01, 32'h800, 5'd4, 64'h9, 1'b0);
        tick();
        idle_in();
        for (int k = 0; k < 20; k++) tick();
        chk("t4b_no_flush", 256'(bus.out_valid), 256'd0);
        chk("t4b_flush_cnt", 256'(flush_cnt), 256'd5);
        beat(8'h00, 8'h00, 32'h900, 5'd0, 64'hA, 1'b1);
        tick();
        idle_in();
        #1;
        chk("t4b_row_valid", 256'(bus.out_row_valid), 256'h01);
        chk("t4b_cause", 256'(bus.out_cause), 256'd2);
        chk("t4b_flush_cnt", 256'(flush_cnt), 256'd6);
        tick();

        // FIFO back-pressure: 4 rows fit, then in_ready drops; drain in order
        bus.out_ready = 1'b0;
        cfg_max_beats = 4'd1;
        for (int k = 0; k < 6; k++) begin
            beat(8'h01, 8'h01, 32'hA00 + 32'(k * 16), 5'd1, 64'hB, 1'b0);
            #1 chk("t5_in_ready", 256'(bus.in_ready), (k < 4) ? 256'd1 : 256'd0);
            tick();
        end
        idle_in();
        #1;
        chk("t5_flush_cnt", 256'(flush_cnt), 256'd10);
        chk("t5_cause", 256'(bus.out_cause), 256'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t5_drain_valid", 256'(bus.out_valid), 256'd1);
            chk("t5_drain_head", 256'(bus.out_head_addr), 256'(32'hA00 + 32'(k * 16)));
            tick();
        end
        chk("t5_empty", 256'(bus.out_valid), 256'd0);

        // Reset while holding two FIFO rows and a partial row
        bus.out_ready = 1'b0;
        beat(8'h01, 8'h01, 32'hB00, 5'd1, 64'hC, 1'b0);
        tick();
        beat(8'h01, 8'h01, 32'hB10, 5'd1, 64'hC, 1'b0);
        tick();
        cfg_max_beats = 4'd4;
        beat(8'h02, 8'h02, 32'hB20, 5'd1, 64'hC, 1'b0);
        tick();
        idle_in();
        #1;
        chk("t6_pre_valid", 256'(bus.out_valid), 256'd1);
        chk("t6_pre_flush_cnt", 256'(flush_cnt), 256'd12);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 256'(bus.out_valid), 256'd0);
        chk("t6_rst_flush_cnt", 256'(flush_cnt), 256'd0);
        chk("t6_rst_in_ready", 256'(bus.in_ready), 256'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("t6_no_rows", 256'(bus.out_valid), 256'd0);
        chk("t6_flush_cnt", 256'(flush_cnt), 256'd0);
        beat(8'h01, 8'h01, 32'hC00, 5'd1, 64'hD, 1'b1);
        tick();
        idle_in();
        #1;
        chk("t6_acc_cleared", 256'(bus.out_row_valid), 256'h01);
        chk("t6_post_cause", 256'(bus.out_cause), 256'd2);
        chk("t6_post_flush_cnt", 256'(flush_cnt), 256'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
